// File: rtl/serial_word_receiver.sv
// Gated-clock serial word receiver: synchronizes ser_clk_in/ser_in, shifts MSB-first on falls, emits words on valid/ready.
// Optional idle-timeout abort with frame_err pulse is enabled by defining SER_RX_TIMEOUT_EN.
module serial_word_receiver #(
   parameter int WORD_W       = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ser_clk_in,
   input  logic              ser_in,
   output logic [WORD_W-1:0] d_out,
   output logic              d_valid,
   input  logic              d_ready,
   output logic              overflow,
   output logic              frame_err,
   output logic [3:0]        led
);
   // state | meaning
   // IDLE  | no word in progress, bit_cnt = 0
   // SHIFT | word in progress, collecting bits on each fall
   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int CW = $clog2(WORD_W) + 1;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] sdat_sync;
   logic                   sclk_s;
   logic                   ser_s;
   logic                   sclk_q;
   logic                   fall;
   logic                   fall_r;
   logic                   bit_r;
   logic [WORD_W-1:0]      shreg;
   logic [WORD_W-1:0]      next_word;
   logic [CW-1:0]          bit_cnt;
   state_t                 state;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ser_s     = sdat_sync[SYNC_STAGES-1];
   assign fall      = sclk_q & ~sclk_s;
   assign next_word = {shreg[WORD_W-2:0], bit_r};
   assign led       = 4'(bit_cnt);

   // Equal-depth chains keep data aligned with the clock edge it belongs to.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         sdat_sync <= '0;
         sclk_q    <= 1'b0;
         fall_r    <= 1'b0;
         bit_r     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ser_clk_in};
         sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], ser_in};
         sclk_q    <= sclk_s;
         fall_r    <= fall;
         bit_r     <= ser_s;
      end
   end

`ifdef SER_RX_TIMEOUT_EN
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   logic [IW-1:0] idle_cnt;
`else
   assign frame_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         d_out    <= '0;
         d_valid  <= 1'b0;
         overflow <= 1'b0;
`ifdef SER_RX_TIMEOUT_EN
         idle_cnt  <= '0;
         frame_err <= 1'b0;
`endif
      end else begin
`ifdef SER_RX_TIMEOUT_EN
         frame_err <= 1'b0;
`endif
         if (d_valid && d_ready)
            d_valid <= 1'b0;
         if (fall_r) begin
            shreg <= next_word;
`ifdef SER_RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (bit_cnt == CW'(WORD_W - 1)) begin
               bit_cnt <= '0;
               state   <= IDLE;
               // A pending unaccepted word wins; the new one is dropped.
               if (!d_valid || d_ready) begin
                  d_out   <= next_word;
                  d_valid <= 1'b1;
               end else begin
                  overflow <= 1'b1;
               end
            end else begin
               bit_cnt <= (state == IDLE) ? CW'(1) : bit_cnt + 1'b1;
               state   <= SHIFT;
            end
         end
`ifdef SER_RX_TIMEOUT_EN
         else if (state == SHIFT) begin
            if (idle_cnt == IW'(IDLE_TIMEOUT)) begin
               bit_cnt   <= '0;
               idle_cnt  <= '0;
               frame_err <= 1'b1;
               state     <= IDLE;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver: bit-level reference model feeds an expected-word queue.
module tb_serial_word_receiver;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ser_clk_in;
   logic          ser_in;
   logic [W-1:0]  d_out;
   logic          d_valid;
   logic          d_ready;
   logic          overflow;
   logic          frame_err;
   logic [3:0]    led;

   serial_word_receiver dut (
      .clk(clk), .rst_n(rst_n), .ser_clk_in(ser_clk_in), .ser_in(ser_in),
      .d_out(d_out), .d_valid(d_valid), .d_ready(d_ready),
      .overflow(overflow), .frame_err(frame_err), .led(led)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int fall_cyc = 0;
   int fe_cycles = 0;
   int exp_fe = 0;
   bit exp_ovf = 0;
   logic [W-1:0] exp_q[$];
   bit           bits[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && frame_err) fe_cycles++;
      if (rst_n && d_valid && d_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h expected none", d_out);
         end else begin
            check("word", d_out, exp_q.pop_front());
         end
      end
   end

   // Reference model: a word is the last W bits collected, MSB first.
   task automatic model_bit(input bit b);
      logic [W-1:0] w;
      bits.push_back(b);
      if (bits.size() == W) begin
         w = '0;
         foreach (bits[i]) w = {w[W-2:0], bits[i]};
         bits.delete();
         if (exp_q.size() > 0 && !d_ready) exp_ovf = 1;
         else exp_q.push_back(w);
      end
   endtask

   // Called and returns at posedge+#1.
   task automatic send_bit(input bit b, input int hi, input int lo);
      ser_in = b;
      ser_clk_in = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
      ser_clk_in = 1'b0;
      fall_cyc = cyc;
      model_bit(b);
      repeat (lo) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input int msb, input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) send_bit(w[msb-i], hi, lo);
   endtask

   task automatic send_word(input logic [W-1:0] w, input int hi, input int lo);
      send_bits(w, W-1, W, hi, lo);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || d_valid) && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(name, (exp_q.size() == 0 && !d_valid) ? 1 : 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check({tag, "_d_out"}, d_out, 0);
      check({tag, "_d_valid"}, d_valid, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_frame_err"}, frame_err, 0);
      check({tag, "_led"}, led, 0);
   endtask

   initial begin
      int k;
      logic [W-1:0] w;
      rst_n = 1'b0;
      ser_clk_in = 1'b0;
      ser_in = 1'b0;
      d_ready = 1'b1;
      repeat (3) @(posedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(3);

      // Single word at clk/4, latency and one-cycle valid pulse.
      send_word(32'hDEADBEEF, 2, 2);
      k = 0;
      while (!d_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("latency", cyc - fall_cyc, 4);
      @(negedge clk);
      check("valid_pulse_width", d_valid, 0);
      check("no_overflow", overflow, 0);
      drain("drain_single");

      // Back-to-back words without a gap.
      send_word(32'h00000001, 2, 2);
      send_word(32'h80000000, 2, 2);
      drain("drain_b2b");
      check("b2b_frame_err", fe_cycles, 0);

      // Stalled consumer: second word is dropped, overflow sticks.
      d_ready = 1'b0;
      send_word(32'h12345678, 2, 2);
      send_word(32'hCAFEF00D, 3, 2);
      idle(10);
      @(negedge clk);
      check("stall_valid", d_valid, 1);
      check("stall_d_out", d_out, 32'h12345678);
      check("stall_overflow", overflow, exp_ovf);
      @(posedge clk); #1;
      d_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("stall_released", d_valid, 0);
      check("stall_queue_empty", exp_q.size(), 0);

      // Partial word followed by a long idle gap.
`ifdef SER_RX_TIMEOUT_EN
      send_bits($urandom, W-1, 10, 2, 2);
      idle(30);
      bits.delete();
      exp_fe++;
      @(negedge clk);
      check("timeout_led", led, 0);
      check("timeout_fe_count", fe_cycles, exp_fe);
      @(posedge clk); #1;
      send_word(32'hA5A5A5A5, 2, 2);
`else
      send_bits(32'hA5A5A5A5, W-1, 10, 2, 2);
      idle(100);
      @(negedge clk);
      check("partial_led", led, 10);
      check("partial_fe_count", fe_cycles, 0);
      @(posedge clk); #1;
      send_bits(32'hA5A5A5A5, W-11, 22, 2, 2);
`endif
      drain("drain_timeout");

      // Reset in the middle of a word.
      send_bits($urandom, W-1, 20, 2, 2);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bits.delete();
      exp_q.delete();
      exp_ovf = 0;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      send_word(32'h0F0F0F0F, 2, 2);
      drain("drain_after_reset");

      // Randomized words, phase lengths and gaps.
      for (int n = 0; n < 8; n++) begin
         w = $urandom;
         send_word(w, $urandom_range(2, 4), $urandom_range(2, 4));
         idle($urandom_range(0, 20));
      end
      drain("drain_random");

      check("final_frame_err_count", fe_cycles, exp_fe);
      check("final_overflow", overflow, exp_ovf);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
